dac_frame_buffer: RTL and testbench

//  Stereo output buffer between the channel-strip DSP chain and the DAC serializer.

---
 rtl/channel_strip_pkg.sv | 20 ++
 rtl/sample_saturate.sv | 28 ++
 rtl/dac_frame_buffer.sv | 138 +++++++++++++
 tb/tb_dac_frame_buffer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_strip_pkg.sv
`default_nettype none
// ============================================================================
// Module  : channel_strip_pkg
// Brief   : Shared sample and stereo-frame types for the channel-strip chain.
// Revision: 1.0
// ============================================================================
package channel_strip_pkg;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

endpackage
`default_nettype wire

// File: rtl/sample_saturate.sv
`default_nettype none
// ============================================================================
// Module  : sample_saturate
// Brief   : Combinational clamp of a wide signed sample to 16 bits, with clip flag.
// Revision: 1.0
// ============================================================================
module sample_saturate
  import channel_strip_pkg::*;
#(
  parameter int IN_WIDTH = 24
) (
  input  logic signed [IN_WIDTH-1:0] i_sample,
  output sample_t                    o_sample,
  output logic                       o_clip
);

  logic [IN_WIDTH-16:0] w_upper;
  logic                 w_in_range;

  // The value fits in 16 bits exactly when bits [IN_WIDTH-1:15] are all equal.
  assign w_upper    = i_sample[IN_WIDTH-1:15];
  assign w_in_range = (&w_upper) | ~(|w_upper);
  assign o_clip     = ~w_in_range;
  assign o_sample   = w_in_range ? sample_t'(i_sample[15:0])
                                 : (i_sample[IN_WIDTH-1] ? SAMPLE_MIN : SAMPLE_MAX);

endmodule
`default_nettype wire

// File: rtl/dac_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module  : dac_frame_buffer
// Brief   : Saturating stereo FIFO that holds one frame per serializer request.
// Revision: 1.0
// ============================================================================
module dac_frame_buffer
  import channel_strip_pkg::*;
#(
  parameter int IN_WIDTH  = 24,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk_48,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_left,
  input  logic signed [IN_WIDTH-1:0]  in_right,
  input  logic                        frame_req,
  output logic signed [15:0]          left_out,
  output logic signed [15:0]          right_out,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        underrun,
  output logic [CNT_WIDTH-1:0]        underrun_cnt,
  output logic                        clip_left,
  output logic                        clip_right,
  input  logic                        clear_flags
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  stereo_t                r_mem [DEPTH];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_LVL_W-1:0]     r_level;
  stereo_t                r_out;
  logic                   r_underrun;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_clip_l;
  logic                   r_clip_r;

  sample_t                w_sat_l;
  sample_t                w_sat_r;
  logic                   w_clip_l;
  logic                   w_clip_r;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_urun;
  logic                   w_clip_ev_l;
  logic                   w_clip_ev_r;

  sample_saturate #(.IN_WIDTH(IN_WIDTH)) u_sat_left (
    .i_sample (in_left),
    .o_sample (w_sat_l),
    .o_clip   (w_clip_l)
  );

  sample_saturate #(.IN_WIDTH(IN_WIDTH)) u_sat_right (
    .i_sample (in_right),
    .o_sample (w_sat_r),
    .o_clip   (w_clip_r)
  );

  assign w_full      = (r_level == c_LVL_W'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_push      = in_valid & ~w_full;
  assign w_pop       = frame_req & ~w_empty;
  assign w_urun      = frame_req & w_empty;
  // Clipping only counts for samples that are actually accepted.
  assign w_clip_ev_l = w_push & w_clip_l;
  assign w_clip_ev_r = w_push & w_clip_r;

  // Storage is left unreset: the level counter alone defines which slots are valid.
  always_ff @(posedge clk_48) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{l: w_sat_l, r: w_sat_r};
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_out    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_out    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A clear coinciding with a new event leaves that event recorded.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_underrun <= 1'b0;
      r_cnt      <= '0;
      r_clip_l   <= 1'b0;
      r_clip_r   <= 1'b0;
    end else if (clear_flags) begin
      r_underrun <= w_urun;
      r_cnt      <= CNT_WIDTH'(w_urun);
      r_clip_l   <= w_clip_ev_l;
      r_clip_r   <= w_clip_ev_r;
    end else begin
      r_underrun <= r_underrun | w_urun;
      r_clip_l   <= r_clip_l | w_clip_ev_l;
      r_clip_r   <= r_clip_r | w_clip_ev_r;
      if (w_urun && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign in_ready     = ~w_full;
  assign left_out     = r_out.l;
  assign right_out    = r_out.r;
  assign level        = r_level;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_cnt;
  assign clip_left    = r_clip_l;
  assign clip_right   = r_clip_r;

endmodule
`default_nettype wire

// File: tb/tb_dac_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dac_frame_buffer
// Brief   : Self-checking bench for dac_frame_buffer against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_dac_frame_buffer;

  localparam int IN_WIDTH  = 24;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 8;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                       clk_48 = 1'b0;
  logic                       reset = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       frame_req = 1'b0;
  logic                       clear_flags = 1'b0;
  logic signed [IN_WIDTH-1:0] in_left = '0;
  logic signed [IN_WIDTH-1:0] in_right = '0;
  logic                       in_ready;
  logic signed [15:0]         left_out;
  logic signed [15:0]         right_out;
  logic [2:0]                 level;
  logic                       underrun;
  logic [CNT_WIDTH-1:0]       underrun_cnt;
  logic                       clip_left;
  logic                       clip_right;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_48 = ~clk_48;

  dac_frame_buffer #(.IN_WIDTH(IN_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_48       (clk_48),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .frame_req    (frame_req),
    .left_out     (left_out),
    .right_out    (right_out),
    .level        (level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .clip_left    (clip_left),
    .clip_right   (clip_right),
    .clear_flags  (clear_flags)
  );

  // Reference model: a plain queue of already-saturated frames.
  typedef struct { int l; int r; } fr_t;
  fr_t m_q[$];
  int  m_l = 0, m_r = 0, m_cnt = 0;
  bit  m_ur = 0, m_cl = 0, m_cr = 0;

  logic [46:0] act;
  assign act = {left_out, right_out, level, underrun, underrun_cnt, clip_left, clip_right, in_ready};

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [46:0] exp_vec();
    logic [15:0] el, er;
    el = 16'(m_l);
    er = 16'(m_r);
    return {el, er, 3'(m_q.size()), m_ur, 8'(m_cnt), m_cl, m_cr, (m_q.size() < DEPTH)};
  endfunction

  task automatic drive(input bit v, input bit fr, input int l, input int r, input bit clr);
    in_valid    = v;
    frame_req   = fr;
    in_left     = IN_WIDTH'(l);
    in_right    = IN_WIDTH'(r);
    clear_flags = clr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  // Advance one clock, updating the model from the inputs presented at that edge.
  task automatic tick();
    bit  push, pop, ur, cl, cr;
    int  sl, sr;
    fr_t f;
    sl   = sat(int'(in_left));
    sr   = sat(int'(in_right));
    push = in_valid && (m_q.size() < DEPTH);
    pop  = frame_req && (m_q.size() > 0);
    ur   = frame_req && (m_q.size() == 0);
    cl   = push && (sl != int'(in_left));
    cr   = push && (sr != int'(in_right));
    if (reset) begin
      m_q.delete();
      m_l = 0; m_r = 0; m_cnt = 0; m_ur = 0; m_cl = 0; m_cr = 0;
    end else begin
      if (pop) begin
        m_l = m_q[0].l;
        m_r = m_q[0].r;
        void'(m_q.pop_front());
      end
      if (push) begin
        f.l = sl;
        f.r = sr;
        m_q.push_back(f);
      end
      if (clear_flags) begin
        m_ur = ur; m_cnt = int'(ur); m_cl = cl; m_cr = cr;
      end else begin
        m_ur |= ur;
        m_cl |= cl;
        m_cr |= cr;
        if (ur && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    @(posedge clk_48);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    n_vec++;
    if (level !== 3'd0 || in_ready !== 1'b1 || left_out !== 16'sd0 || right_out !== 16'sd0) begin
      n_err++;
      $display("FAIL reset_state: level=%0d in_ready=%b out=%0d/%0d, required 0/1/0/0",
               level, in_ready, left_out, right_out);
    end
    n_vec++;
    if (act !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_vec: got %h required %h", act, exp_vec());
    end
  endtask

  task automatic test_basic();
    drive(1, 0, 1000, -1000, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    tick();
    idle();
    n_vec++;
    if (left_out !== 16'sd1000 || right_out !== -16'sd1000 || level !== 3'd0) begin
      n_err++;
      $display("FAIL basic_pop: out=%0d/%0d level=%0d, required 1000/-1000/0",
               left_out, right_out, level);
    end
    tick();
    n_vec++;
    if (act !== exp_vec()) begin
      n_err++;
      $display("FAIL basic_hold: got %h required %h", act, exp_vec());
    end
  endtask

  task automatic test_saturate();
    drive(1, 0, 32'sh012345, -32'sh012345, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    tick();
    idle();
    n_vec++;
    if (left_out !== 16'sh7FFF || right_out !== 16'sh8000 || clip_left !== 1'b1 || clip_right !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: out=%h/%h clip=%b%b, required 7fff/8000 clip=11",
               left_out, right_out, clip_left, clip_right);
    end
    drive(0, 0, 0, 0, 1);
    tick();
    idle();
    n_vec++;
    if (act !== exp_vec()) begin
      n_err++;
      $display("FAIL saturate_clear: got %h required %h", act, exp_vec());
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 100 * (i + 1), -100 * (i + 1), 0);
      tick();
    end
    drive(1, 0, 555, -555, 0);
    tick();
    n_vec++;
    if (in_ready !== 1'b0 || level !== 3'(DEPTH)) begin
      n_err++;
      $display("FAIL full_stall: in_ready=%b level=%0d, required 0/%0d", in_ready, level, DEPTH);
    end
    drive(1, 1, 555, -555, 0);
    tick();
    n_vec++;
    if (level !== 3'(DEPTH - 1) || in_ready !== 1'b1 || left_out !== 16'sd100) begin
      n_err++;
      $display("FAIL full_pop: level=%0d in_ready=%b left=%0d, required %0d/1/100",
               level, in_ready, left_out, DEPTH - 1);
    end
    drive(1, 0, 555, -555, 0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
      n_vec++;
      if (act !== exp_vec()) begin
        n_err++;
        $display("FAIL full_drain[%0d]: got %h required %h", i, act, exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_underrun();
    drive(0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
    end
    idle();
    n_vec++;
    if (underrun !== 1'b1 || underrun_cnt !== 8'd3 || left_out !== 16'sd555) begin
      n_err++;
      $display("FAIL underrun_count: underrun=%b cnt=%0d left=%0d, required 1/3/555",
               underrun, underrun_cnt, left_out);
    end
    drive(0, 0, 0, 0, 1);
    tick();
    n_vec++;
    if (underrun !== 1'b0 || underrun_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL underrun_clear: underrun=%b cnt=%0d, required 0/0", underrun, underrun_cnt);
    end
    drive(0, 1, 0, 0, 1);
    tick();
    idle();
    n_vec++;
    if (underrun !== 1'b1 || underrun_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL clear_vs_event: underrun=%b cnt=%0d, required 1/1", underrun, underrun_cnt);
    end
  endtask

  task automatic test_push_pop();
    drive(1, 0, 11, -11, 0);
    tick();
    drive(1, 0, 22, -22, 0);
    tick();
    drive(1, 1, 33, -33, 0);
    tick();
    idle();
    n_vec++;
    if (level !== 3'd2 || left_out !== 16'sd11 || right_out !== -16'sd11) begin
      n_err++;
      $display("FAIL push_pop: level=%0d out=%0d/%0d, required 2/11/-11", level, left_out, right_out);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
      n_vec++;
      if (act !== exp_vec()) begin
        n_err++;
        $display("FAIL push_pop_order[%0d]: got %h required %h", i, act, exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_empty_push_req();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(1, 1, 77, -77, 0);
    tick();
    idle();
    n_vec++;
    if (level !== 3'd1 || underrun !== 1'b1 || underrun_cnt !== 8'd1 || left_out !== 16'sd33) begin
      n_err++;
      $display("FAIL empty_push_req: level=%0d underrun=%b cnt=%0d left=%0d, required 1/1/1/33",
               level, underrun, underrun_cnt, left_out);
    end
    drive(0, 1, 0, 0, 0);
    tick();
    idle();
    n_vec++;
    if (act !== exp_vec()) begin
      n_err++;
      $display("FAIL empty_push_req_pop: got %h required %h", act, exp_vec());
    end
  endtask

  task automatic test_cnt_saturate();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
    end
    idle();
    n_vec++;
    if (underrun_cnt !== 8'(CNT_MAX) || underrun !== 1'b1) begin
      n_err++;
      $display("FAIL cnt_saturate: cnt=%0d underrun=%b, required %0d/1", underrun_cnt, underrun, CNT_MAX);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 3), 1234 + i, -1234 - i, 0);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (level !== 3'd0 || left_out !== 16'sd0 || right_out !== 16'sd0 || underrun !== 1'b0 ||
        underrun_cnt !== 8'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: level=%0d out=%0d/%0d underrun=%b cnt=%0d in_ready=%b, required 0/0/0/0/0/1",
               level, left_out, right_out, underrun, underrun_cnt, in_ready);
    end
  endtask

  task automatic test_random();
    int l, r;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        l = int'($signed(24'($urandom())));
        r = int'($signed(24'($urandom())));
      end else begin
        l = int'($urandom_range(0, 65535)) - 32768;
        r = int'($urandom_range(0, 65535)) - 32768;
      end
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, l, r, $urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      n_vec++;
      if (act !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h required %h", i, act, exp_vec());
      end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_full();
    test_underrun();
    test_push_pop();
    test_empty_push_req();
    test_cnt_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
